// File: rtl/avlst_pack_arbiter_pkg.sv
// Shared types and helpers for the Avalon-ST packet arbiter.
// Covers request bit positions, FSM state encoding and index-width sizing.
package avlst_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int REQ_GEN  = 0;
    localparam int REQ_CRIT = 1;

    // Bits needed to hold the value v (at least one).
    function automatic int BIT_WIDTH(input int v);
        return (v < 1) ? 1 : $clog2(v + 1);
    endfunction

endpackage

// File: rtl/avlst_pack_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set bit of i_req at or after
// i_start, wrapping modulo N.
module avlst_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_start,
    output logic         o_valid,
    output logic [W-1:0] o_index
);

    int          w_pos;
    logic [N-1:0] w_sh;

    always_comb begin
        o_valid = 1'b0;
        o_index = '0;
        w_pos   = 0;
        w_sh    = '0;
        for (int i = 0; i < N; i++) begin
            w_pos = int'(i_start) + i;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            w_sh = i_req >> w_pos;
            if (!o_valid && w_sh[0]) begin
                o_valid = 1'b1;
                o_index = W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/avlst_pack_arbiter.sv
// Packet-granular arbiter sharing one Avalon-ST sink among CHAN_NUM FIFOs.
// Critical requests win over general ones; round-robin inside each class.
module avlst_pack_arbiter
    import avlst_arb_pkg::*;
#(
    parameter int CHAN_NUM      = 4,
    parameter int CHAN_WIDTH    = BIT_WIDTH(CHAN_NUM - 1),
    parameter int TIMEOUT_LEN   = 4096,
    parameter int TIMEOUT_WIDTH = BIT_WIDTH(TIMEOUT_LEN)
) (
    input  logic                  clk_wr,
    input  logic                  rst_n,
    input  logic [2*CHAN_NUM-1:0] arbit_request,
    input  logic [CHAN_NUM-1:0]   arbit_eop,
    input  logic                  dout_ready,
    output logic [CHAN_NUM-1:0]   arbit_grant,
    output logic                  grant_valid,
    output logic [CHAN_WIDTH-1:0] grant_index,
    output logic [31:0]           timeout_cnt,
    output logic [31:0]           abort_cnt
);

    state_t                   r_state;
    logic                     r_valid;
    logic [CHAN_WIDTH-1:0]    r_idx;
    logic [CHAN_WIDTH-1:0]    r_last;
    logic [TIMEOUT_WIDTH-1:0] r_wd;
    logic [31:0]              r_timeout_cnt;
    logic [31:0]              r_abort_cnt;

    logic [CHAN_NUM-1:0]      w_crit;
    logic [CHAN_NUM-1:0]      w_gen;
    logic [CHAN_WIDTH-1:0]    w_start;
    logic                     w_crit_valid;
    logic [CHAN_WIDTH-1:0]    w_crit_idx;
    logic                     w_gen_valid;
    logic [CHAN_WIDTH-1:0]    w_gen_idx;
    logic                     w_pick_valid;
    logic [CHAN_WIDTH-1:0]    w_pick_idx;
    logic                     w_own_req;
    logic                     w_own_eop;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        w_crit    = '0;
        w_gen     = '0;
        w_own_req = 1'b0;
        w_own_eop = 1'b0;
        for (int c = 0; c < CHAN_NUM; c++) begin
            w_crit[c] = arbit_request[2*c+REQ_CRIT];
            w_gen[c]  = arbit_request[2*c+REQ_GEN] | arbit_request[2*c+REQ_CRIT];
            if (r_idx == CHAN_WIDTH'(c)) begin
                w_own_req = w_gen[c];
                w_own_eop = arbit_eop[c];
            end
        end
    end

    // Search starts one past the last winner; explicit wrap keeps non-power-of-2 counts in range.
    assign w_start = (r_last == CHAN_WIDTH'(CHAN_NUM - 1)) ? '0 : r_last + 1'b1;

    avlst_rr_pick #(.N(CHAN_NUM), .W(CHAN_WIDTH)) u_pick_crit (
        .i_req   (w_crit),
        .i_start (w_start),
        .o_valid (w_crit_valid),
        .o_index (w_crit_idx)
    );

    avlst_rr_pick #(.N(CHAN_NUM), .W(CHAN_WIDTH)) u_pick_gen (
        .i_req   (w_gen),
        .i_start (w_start),
        .o_valid (w_gen_valid),
        .o_index (w_gen_idx)
    );

    assign w_pick_valid = w_crit_valid | w_gen_valid;
    assign w_pick_idx   = w_crit_valid ? w_crit_idx : w_gen_idx;

    always_ff @(posedge clk_wr or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_valid       <= 1'b0;
            r_idx         <= '0;
            r_last        <= CHAN_WIDTH'(CHAN_NUM - 1);
            r_wd          <= '0;
            r_timeout_cnt <= '0;
            r_abort_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_wd <= '0;
                    if (w_pick_valid) begin
                        r_state <= GRANT;
                        r_valid <= 1'b1;
                        r_idx   <= w_pick_idx;
                        r_last  <= w_pick_idx;
                    end
                end
                GRANT: begin
                    // eop outranks drop and timeout; the next packet loads with no bubble.
                    if (w_own_eop && dout_ready) begin
                        r_wd <= '0;
                        if (w_pick_valid) begin
                            r_idx  <= w_pick_idx;
                            r_last <= w_pick_idx;
                        end else begin
                            r_state <= IDLE;
                            r_valid <= 1'b0;
                        end
                    end else if (!w_own_req) begin
                        r_state     <= IDLE;
                        r_valid     <= 1'b0;
                        r_abort_cnt <= sat_inc(r_abort_cnt);
                    end else if (dout_ready) begin
                        if (r_wd == TIMEOUT_WIDTH'(TIMEOUT_LEN - 1)) begin
                            r_state       <= IDLE;
                            r_valid       <= 1'b0;
                            r_timeout_cnt <= sat_inc(r_timeout_cnt);
                        end else begin
                            r_wd <= r_wd + TIMEOUT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        arbit_grant = '0;
        for (int c = 0; c < CHAN_NUM; c++) begin
            arbit_grant[c] = (r_state == GRANT) && (r_idx == CHAN_WIDTH'(c)) && dout_ready;
        end
    end

    assign grant_valid = r_valid;
    assign grant_index = r_idx;
    assign timeout_cnt = r_timeout_cnt;
    assign abort_cnt   = r_abort_cnt;

endmodule
